// File: rtl/sprite_renderer.sv
// Sprite pixel pipeline: beam coordinates to sprite-local LUT address, palette to RGB222, animation sequencer.
// Optional macro SPRITE_MIRROR_EN adds a horizontal mirror that flips on every animation wrap.
module sprite_renderer #(
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_HOLD = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    hpos,
  input  logic [9:0]                    vpos,
  input  logic                          display_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          frame_start,
  input  logic [9:0]                    sprite_x,
  input  logic [9:0]                    sprite_y,
  output logic [4:0]                    lut_x,
  output logic [4:0]                    lut_y,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
  input  logic [2:0]                    lut_pixel,
  output logic [1:0]                    r,
  output logic [1:0]                    g,
  output logic [1:0]                    b,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          de_out
);

  localparam int unsigned FS_W     = $clog2(NUM_FRAMES);
  localparam int unsigned HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int unsigned SPR_SIZE = 32 << SCALE_LOG2;

  logic [9:0]        pos_x_q, pos_y_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [FS_W-1:0]   frame_sel_q;
  logic [4:0]        lut_x_q, lut_y_q;
  logic              in_box_q, de_q, hs_q, vs_q;
  logic [5:0]        rgb_q;
  logic              hsync_out_q, vsync_out_q, de_out_q;

  logic [10:0]       dx, dy;
  logic [4:0]        col, lut_x_d, lut_y_d;
  logic              in_box_d;
  logic              hold_last, frame_last;
  logic [5:0]        rgb_d;

`ifdef SPRITE_MIRROR_EN
  logic              mirror_q;
`endif

  assign hold_last  = (hold_cnt_q == HOLD_W'(FRAME_HOLD - 1));
  assign frame_last = (frame_sel_q == FS_W'(NUM_FRAMES - 1));

  function automatic logic [5:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 6'b11_11_11;
      3'd2:    palette = 6'b10_10_10;
      3'd3:    palette = 6'b01_01_01;
      3'd4:    palette = 6'b11_10_00;
      3'd5:    palette = 6'b11_11_00;
      3'd6:    palette = 6'b11_01_10;
      default: palette = 6'b00_00_00;
    endcase
  endfunction

  // Stage 1 address generation; the >= compares stop a right/bottom overhang from wrapping.
  always_comb begin
    dx       = {1'b0, hpos} - {1'b0, pos_x_q};
    dy       = {1'b0, vpos} - {1'b0, pos_y_q};
    in_box_d = display_on && (hpos >= pos_x_q) && (dx < 11'(SPR_SIZE)) &&
               (vpos >= pos_y_q) && (dy < 11'(SPR_SIZE));
    col      = 5'(dx >> SCALE_LOG2);
    lut_x_d  = 5'd0;
    lut_y_d  = 5'd0;
    if (in_box_d) begin
`ifdef SPRITE_MIRROR_EN
      lut_x_d = mirror_q ? (5'd31 - col) : col;
`else
      lut_x_d = col;
`endif
      lut_y_d = 5'(dy >> SCALE_LOG2);
    end
  end

  always_comb begin
    rgb_d = 6'd0;
    if (in_box_q && de_q) rgb_d = palette(lut_pixel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q     <= 10'd0;
      pos_y_q     <= 10'd0;
      hold_cnt_q  <= '0;
      frame_sel_q <= '0;
      lut_x_q     <= 5'd0;
      lut_y_q     <= 5'd0;
      in_box_q    <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      rgb_q       <= 6'd0;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
      de_out_q    <= 1'b0;
    end else begin
      if (frame_start) begin
        pos_x_q <= sprite_x;
        pos_y_q <= sprite_y;
        if (hold_last) begin
          hold_cnt_q  <= '0;
          frame_sel_q <= frame_last ? '0 : frame_sel_q + FS_W'(1);
        end else begin
          hold_cnt_q  <= hold_cnt_q + HOLD_W'(1);
        end
      end
      lut_x_q     <= lut_x_d;
      lut_y_q     <= lut_y_d;
      in_box_q    <= in_box_d;
      de_q        <= display_on;
      hs_q        <= hsync_in;
      vs_q        <= vsync_in;
      rgb_q       <= rgb_d;
      hsync_out_q <= hs_q;
      vsync_out_q <= vs_q;
      de_out_q    <= de_q;
    end
  end

`ifdef SPRITE_MIRROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mirror_q <= 1'b0;
    end else if (frame_start && hold_last && frame_last) begin
      mirror_q <= ~mirror_q;
    end
  end
`endif

  assign lut_x     = lut_x_q;
  assign lut_y     = lut_y_q;
  assign frame_sel = frame_sel_q;
  assign r         = rgb_q[5:4];
  assign g         = rgb_q[3:2];
  assign b         = rgb_q[1:0];
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;
  assign de_out    = de_out_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer (default parameters; mirror checks under SPRITE_MIRROR_EN).
module tb_sprite_renderer;

  logic       clk;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, frame_start;
  logic [9:0] sprite_x, sprite_y;
  logic [4:0] lut_x, lut_y;
  logic [1:0] frame_sel;
  logic [2:0] lut_pixel;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out, de_out;

  int n_cmp = 0;
  int n_err = 0;

  sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .lut_x(lut_x), .lut_y(lut_y),
    .frame_sel(frame_sel), .lut_pixel(lut_pixel), .r(r), .g(g), .b(b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_start();
    display_on  = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    display_on = 1'b1; hpos = 10'd5; vpos = 10'd5; lut_pixel = 3'd1; hsync_in = 1'b0;
    step();
    step();
    n_cmp++;
    if ({r, g, b} !== 6'h3F) begin
      n_err++; $display("FAIL pre_reset_rgb got %0h exp 3f", {r, g, b});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lut_x, lut_y, frame_sel, r, g, b, hsync_out, vsync_out, de_out} !== {5'd0, 5'd0, 2'd0, 6'd0, 3'b110}) begin
      n_err++;
      $display("FAIL async_reset got lx=%0d ly=%0d fs=%0d rgb=%0h hs=%b vs=%b de=%b exp 0 0 0 0 1 1 0",
               lut_x, lut_y, frame_sel, {r, g, b}, hsync_out, vsync_out, de_out);
    end
    display_on = 1'b0; hsync_in = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({r, g, b, de_out, hsync_out} !== {6'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL post_reset_idle got rgb=%0h de=%b hs=%b exp 0 0 1", {r, g, b}, de_out, hsync_out);
    end
  endtask

  task automatic test_mapping();
    logic [9:0] hp [7] = '{10'd100, 10'd103, 10'd104, 10'd227, 10'd228, 10'd100, 10'd104};
    logic [9:0] vp [7] = '{10'd50, 10'd50, 10'd50, 10'd50, 10'd50, 10'd177, 10'd50};
    logic [4:0] ex [7] = '{5'd0, 5'd0, 5'd1, 5'd31, 5'd0, 5'd0, 5'd1};
    logic [4:0] ey [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0};
    sprite_x = 10'd100; sprite_y = 10'd50;
    pulse_frame_start();
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin sprite_x = 10'd200; sprite_y = 10'd0; end
      display_on = 1'b1; hpos = hp[i]; vpos = vp[i];
      step();
      n_cmp++;
      if ({lut_x, lut_y} !== {ex[i], ey[i]}) begin
        n_err++;
        $display("FAIL map_%0d got lx=%0d ly=%0d exp lx=%0d ly=%0d", i, lut_x, lut_y, ex[i], ey[i]);
      end
    end
    sprite_x = 10'd100; sprite_y = 10'd50;
  endtask

  task automatic test_palette();
    logic [5:0] pal [8] = '{6'h00, 6'h3F, 6'h2A, 6'h15, 6'h38, 6'h3C, 6'h36, 6'h00};
    logic [7:0] hpat = 8'b1011_0010;
    logic [7:0] vpat = 8'b0110_1001;
    display_on = 1'b0; lut_pixel = 3'd4;
    step(); step();
    display_on = 1'b1; hpos = 10'd110; vpos = 10'd60;
    step();
    n_cmp++;
    if ({r, g, b, de_out} !== 7'd0) begin
      n_err++; $display("FAIL latency_early got rgb=%0h de=%b exp 0 0", {r, g, b}, de_out);
    end
    step();
    n_cmp++;
    if ({r, g, b, de_out} !== {6'h38, 1'b1}) begin
      n_err++; $display("FAIL latency_two got rgb=%0h de=%b exp 38 1", {r, g, b}, de_out);
    end
    for (int i = 0; i < 8; i++) begin
      lut_pixel = 3'(i);
      step(); step();
      n_cmp++;
      if ({r, g, b} !== pal[i]) begin
        n_err++; $display("FAIL palette_%0d got %0h exp %0h", i, {r, g, b}, pal[i]);
      end
    end
    lut_pixel = 3'd1; hpos = 10'd0;
    step(); step();
    n_cmp++;
    if ({r, g, b, de_out} !== {6'h00, 1'b1}) begin
      n_err++; $display("FAIL outside_box got rgb=%0h de=%b exp 0 1", {r, g, b}, de_out);
    end
    display_on = 1'b0; hpos = 10'd110;
    step(); step();
    n_cmp++;
    if ({r, g, b, de_out} !== 7'd0) begin
      n_err++; $display("FAIL de_low got rgb=%0h de=%b exp 0 0", {r, g, b}, de_out);
    end
    for (int i = 0; i < 8; i++) begin
      hsync_in = hpat[i]; vsync_in = vpat[i]; display_on = hpat[i];
      step();
      if (i > 0) begin
        n_cmp++;
        if ({hsync_out, vsync_out, de_out} !== {hpat[i-1], vpat[i-1], hpat[i-1]}) begin
          n_err++;
          $display("FAIL sync_delay_%0d got %b%b%b exp %b%b%b", i, hsync_out, vsync_out, de_out,
                   hpat[i-1], vpat[i-1], hpat[i-1]);
        end
      end
    end
    hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b0;
  endtask

  task automatic test_clipping();
    sprite_x = 10'd600; sprite_y = 10'd50;
    pulse_frame_start();
    lut_pixel = 3'd1; vpos = 10'd60; display_on = 1'b1;
    hpos = 10'd600;
    step(); step();
    n_cmp++;
    if ({r, g, b} !== 6'h3F) begin
      n_err++; $display("FAIL clip_left got %0h exp 3f", {r, g, b});
    end
    hpos = 10'd639;
    step();
    n_cmp++;
    if (lut_x !== 5'd9) begin
      n_err++; $display("FAIL clip_edge_lx got %0d exp 9", lut_x);
    end
    step();
    n_cmp++;
    if ({r, g, b} !== 6'h3F) begin
      n_err++; $display("FAIL clip_edge got %0h exp 3f", {r, g, b});
    end
    for (int h = 0; h < 28; h++) begin
      hpos = 10'(h);
      step();
      n_cmp++;
      if (lut_x !== 5'd0) begin
        n_err++; $display("FAIL clip_wrap_lx_%0d got %0d exp 0", h, lut_x);
      end
      step();
      n_cmp++;
      if ({r, g, b} !== 6'h00) begin
        n_err++; $display("FAIL clip_wrap_%0d got %0h exp 0", h, {r, g, b});
      end
    end
    display_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    sprite_x = 10'd300; sprite_y = 10'd50;
    pulse_frame_start();
    lut_pixel = 3'd1; vpos = 10'd50; display_on = 1'b1;
    hpos = 10'd299;
    step(); step();
    n_cmp++;
    if ({r, g, b} !== 6'h00) begin
      n_err++; $display("FAIL coincide_before got %0h exp 0", {r, g, b});
    end
    hpos = 10'd304;
    step();
    n_cmp++;
    if (lut_x !== 5'd1) begin
      n_err++; $display("FAIL coincide_lx got %0d exp 1", lut_x);
    end
    step();
    n_cmp++;
    if ({r, g, b} !== 6'h3F) begin
      n_err++; $display("FAIL coincide_draw got %0h exp 3f", {r, g, b});
    end
    display_on = 1'b0;
  endtask

  task automatic test_animation();
    logic [1:0] exp_fs;
    logic [4:0] exp_a, exp_b;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    sprite_x = 10'd100; sprite_y = 10'd50;
    for (int k = 1; k <= 48; k++) begin
      pulse_frame_start();
      exp_fs = 2'((k / 6) % 4);
      n_cmp++;
      if (frame_sel !== exp_fs) begin
        n_err++; $display("FAIL anim_pulse_%0d got %0d exp %0d", k, frame_sel, exp_fs);
      end
      display_on = 1'b1; hpos = 10'd100; vpos = 10'd50;
      for (int c = 0; c < 3; c++) begin
        step();
        n_cmp++;
        if (frame_sel !== exp_fs) begin
          n_err++; $display("FAIL anim_video_%0d_%0d got %0d exp %0d", k, c, frame_sel, exp_fs);
        end
      end
      if (k % 24 == 0) begin
`ifdef SPRITE_MIRROR_EN
        exp_a = (k == 24) ? 5'd31 : 5'd0;
        exp_b = (k == 24) ? 5'd30 : 5'd1;
`else
        exp_a = 5'd0;
        exp_b = 5'd1;
`endif
        n_cmp++;
        if (lut_x !== exp_a) begin
          n_err++; $display("FAIL mirror_left_%0d got %0d exp %0d", k, lut_x, exp_a);
        end
        hpos = 10'd104;
        step();
        n_cmp++;
        if (lut_x !== exp_b) begin
          n_err++; $display("FAIL mirror_next_%0d got %0d exp %0d", k, lut_x, exp_b);
        end
      end
      display_on = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
    sprite_x = 10'd0; sprite_y = 10'd0; lut_pixel = 3'd0;
    test_reset();
    test_mapping();
    test_palette();
    test_clipping();
    test_back_to_back();
    test_animation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
